// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode stage.
//   - major-opcode encodings and the minor opcode values with special meaning
//   - functional-unit bit indices and writeback-source encodings
//   - decode FSM state enum and the fixed-width part of the decoded bundle
//   - small classification helpers used by the stage control logic
package decode_pkg;

    localparam logic [3:0] OP_ALU0      = 4'b0000;
    localparam logic [3:0] OP_ALU1      = 4'b0001;
    localparam logic [3:0] OP_COMPLEX   = 4'b0010;
    localparam logic [3:0] OP_MEMORY    = 4'b0011;
    localparam logic [3:0] OP_JAL_REG   = 4'b1000;
    localparam logic [3:0] OP_JAL_IMM   = 4'b1001;
    localparam logic [3:0] OP_BR_REG    = 4'b1010;
    localparam logic [3:0] OP_BR_IMM    = 4'b1011;
    localparam logic [3:0] OP_IMM_LO8   = 4'b1100;
    localparam logic [3:0] OP_IMM_10Z   = 4'b1101;
    localparam logic [3:0] OP_IMM_UPPER = 4'b1110;
    localparam logic [3:0] OP_IMM_10S   = 4'b1111;

    localparam logic [3:0] MINOR_HALT = 4'hF;
    localparam logic [3:0] MINOR_IMM  = 4'h7;

    localparam int FU_ALU0    = 0;
    localparam int FU_ALU1    = 1;
    localparam int FU_COMPLEX = 2;
    localparam int FU_MEMORY  = 3;
    localparam int FU_BRANCH  = 4;

    localparam logic [1:0] WB_NONE = 2'b00;
    localparam logic [1:0] WB_PC1  = 2'b01;
    localparam logic [1:0] WB_ALU0 = 2'b10;
    localparam logic [1:0] WB_ALU1 = 2'b11;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        BRANCHWAIT = 2'd1,
        HALTED     = 2'd2
    } decodeState_t;

    // Width-independent part of the bundle; FU enable and immediate are
    // parametrised and travel alongside this struct.
    typedef struct packed {
        logic [1:0] wbSource;
        logic [3:0] minorOpcode;
        logic       immediateEn;
        logic [3:0] regAAddr;
        logic [3:0] regBAddr;
        logic       regAReadEn;
        logic       regAWriteEn;
        logic       regBReadEn;
        logic       jumpEn;
        logic       relativeEn;
    } decodeCtrl_t;

    // Halt is a complex-class opcode with the reserved minor value.
    function automatic logic isHaltInstr(input logic [15:0] instr);
        return (instr[15:12] == OP_COMPLEX) && (instr[7:4] == MINOR_HALT);
    endfunction

    // A branch whose condition register is r0 is unconditional and never stalls.
    function automatic logic isCondBranch(input logic [15:0] instr, input logic [3:0] regA);
        return (instr[15:13] == 3'b101) && (regA != 4'h0);
    endfunction

endpackage

// File: rtl/decode_stage_fields.sv
// instr_field_decode: purely combinational 16-bit instruction -> decoded bundle.
//   instr     in   16-bit instruction
//   ctrl      out  fixed-width control fields (decodeCtrl_t)
//   fuEnable  out  one-hot functional-unit enable (FUCOUNT bits)
//   immediate out  extended immediate (DATABITWIDTH bits)
// Undefined major opcodes produce an all-zero bundle.
module instr_field_decode
    import decode_pkg::*;
#(
    parameter int DATABITWIDTH = 16,
    parameter int FUCOUNT      = 5
) (
    input  logic [15:0]             instr,
    output decodeCtrl_t             ctrl,
    output logic [FUCOUNT-1:0]      fuEnable,
    output logic [DATABITWIDTH-1:0] immediate
);

    logic knownClass_s;

    // Class decode followed by the register/minor fields shared by all known classes.
    always_comb begin
        ctrl         = '0;
        fuEnable     = '0;
        immediate    = '0;
        knownClass_s = 1'b1;
        case (instr[15:12])
            OP_ALU0, OP_ALU1: begin
                fuEnable[(instr[12] ? FU_ALU1 : FU_ALU0)] = 1'b1;
                ctrl.wbSource    = instr[12] ? WB_ALU1 : WB_ALU0;
                ctrl.regAReadEn  = 1'b1;
                ctrl.regBReadEn  = 1'b1;
                ctrl.regAWriteEn = 1'b1;
            end
            OP_COMPLEX, OP_MEMORY: begin
                fuEnable[(instr[12] ? FU_MEMORY : FU_COMPLEX)] = 1'b1;
                ctrl.regAReadEn = 1'b1;
                ctrl.regBReadEn = 1'b1;
            end
            OP_JAL_REG, OP_JAL_IMM: begin
                fuEnable[FU_BRANCH] = 1'b1;
                ctrl.wbSource    = WB_PC1;
                ctrl.regAWriteEn = 1'b1;
                ctrl.regBReadEn  = ~instr[12];
                ctrl.jumpEn      = 1'b1;
                ctrl.relativeEn  = instr[12];
                immediate        = DATABITWIDTH'($signed(instr[9:0]));
            end
            OP_BR_REG, OP_BR_IMM: begin
                fuEnable[FU_BRANCH] = 1'b1;
                ctrl.regAReadEn = 1'b1;
                ctrl.regBReadEn = ~instr[12];
                ctrl.relativeEn = instr[12];
                immediate       = DATABITWIDTH'($signed(instr[9:0]));
            end
            OP_IMM_LO8, OP_IMM_10Z, OP_IMM_UPPER, OP_IMM_10S: begin
                fuEnable[FU_ALU0] = 1'b1;
                ctrl.wbSource    = WB_ALU0;
                ctrl.regAWriteEn = 1'b1;
                ctrl.immediateEn = 1'b1;
                case (instr[13:12])
                    2'b00:   immediate = DATABITWIDTH'(instr[7:0]);
                    2'b01:   immediate = DATABITWIDTH'(instr[9:0]);
                    2'b10:   immediate = DATABITWIDTH'(instr[7:0]) << 4'd8;
                    2'b11:   immediate = DATABITWIDTH'($signed(instr[9:0]));
                    default: immediate = '0;
                endcase
            end
            default: knownClass_s = 1'b0;
        endcase

        if (knownClass_s) begin
            // Immediate-bearing forms reuse instr[9:8], so RegA shrinks to a 3-bit choice.
            ctrl.regAAddr    = (instr[15] & instr[12]) ? {instr[11:10], 1'b0, instr[14]}
                                                       : instr[11:8];
            ctrl.regBAddr    = instr[3:0];
            ctrl.minorOpcode = ctrl.immediateEn ? MINOR_IMM : instr[7:4];
        end else begin
            ctrl.regAAddr    = 4'h0;
            ctrl.regBAddr    = 4'h0;
            ctrl.minorOpcode = 4'h0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered, flow-controlled decode stage with an instruction FIFO.
//   clk, rst_n                  clock, asynchronous active-low reset
//   InstructionIn/Valid/Ready   fetch handshake; Ready is registered ~full
//   FlushIn                     clear FIFO and output register, leave BRANCHWAIT
//   BranchResolved, ResumeIn    release BRANCHWAIT / HALTED
//   DecodeValid/DecodeReady     dispatch handshake for the registered bundle
//   FunctionalUnitEnable .. RelativeEn   registered decoded bundle
//   Halted                      FSM is in HALTED
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATABITWIDTH = 16,
    parameter int FUCOUNT      = 5,
    parameter int FIFODEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [15:0]             InstructionIn,
    input  logic                    InstructionInValid,
    output logic                    InstructionInReady,
    input  logic                    FlushIn,
    input  logic                    BranchResolved,
    input  logic                    ResumeIn,
    output logic                    DecodeValid,
    input  logic                    DecodeReady,
    output logic [FUCOUNT-1:0]      FunctionalUnitEnable,
    output logic [1:0]              WritebackSource,
    output logic [3:0]              MinorOpcode,
    output logic                    ImmediateEn,
    output logic [DATABITWIDTH-1:0] ImmediateOut,
    output logic [3:0]              RegAAddr,
    output logic [3:0]              RegBAddr,
    output logic                    RegAReadEn,
    output logic                    RegAWriteEn,
    output logic                    RegBReadEn,
    output logic                    JumpEn,
    output logic                    RelativeEn,
    output logic                    Halted
);

    localparam int              AW      = $clog2(FIFODEPTH);
    localparam logic [AW:0]     DEPTH_C = (AW+1)'(FIFODEPTH);
    localparam logic [AW-1:0]   PTR_ONE = AW'(1'b1);
    localparam logic [AW:0]     CNT_ONE = (AW+1)'(1'b1);

    logic [15:0]             fifoMem_r [FIFODEPTH];
    logic [AW-1:0]           wrPtr_r;
    logic [AW-1:0]           rdPtr_r;
    logic [AW:0]             count_r;
    logic [AW:0]             countNext_s;
    logic                    inReady_r;
    decodeState_t            state_r;
    logic                    decValid_r;
    decodeCtrl_t             ctrl_r;
    logic [FUCOUNT-1:0]      fu_r;
    logic [DATABITWIDTH-1:0] imm_r;

    logic [15:0]             headInstr_s;
    decodeCtrl_t             headCtrl_s;
    logic [FUCOUNT-1:0]      headFu_s;
    logic [DATABITWIDTH-1:0] headImm_s;
    logic                    pushEn_s;
    logic                    popEn_s;
    logic                    headHalt_s;
    logic                    headCondBr_s;

    assign headInstr_s  = fifoMem_r[rdPtr_r];
    assign pushEn_s     = InstructionInValid & inReady_r & ~FlushIn;
    assign popEn_s      = ~FlushIn & (state_r == RUN) & (count_r != '0)
                        & (~decValid_r | DecodeReady);
    assign headHalt_s   = isHaltInstr(headInstr_s);
    assign headCondBr_s = isCondBranch(headInstr_s, headCtrl_s.regAAddr);

    instr_field_decode #(
        .DATABITWIDTH (DATABITWIDTH),
        .FUCOUNT      (FUCOUNT)
    ) u_fields (
        .instr     (headInstr_s),
        .ctrl      (headCtrl_s),
        .fuEnable  (headFu_s),
        .immediate (headImm_s)
    );

    // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        countNext_s = count_r;
        if (FlushIn) begin
            countNext_s = '0;
        end else begin
            case ({pushEn_s, popEn_s})
                2'b10:   countNext_s = count_r + CNT_ONE;
                2'b01:   countNext_s = count_r - CNT_ONE;
                default: countNext_s = count_r;
            endcase
        end
    end

    // FIFO storage, pointers and the registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFODEPTH; i++) begin
                fifoMem_r[i] <= 16'h0000;
            end
            wrPtr_r   <= '0;
            rdPtr_r   <= '0;
            count_r   <= '0;
            inReady_r <= 1'b1;
        end else begin
            count_r   <= countNext_s;
            // Ready looks ahead at next occupancy so it never depends on DecodeReady combinationally.
            inReady_r <= (countNext_s != DEPTH_C);
            if (FlushIn) begin
                wrPtr_r <= '0;
                rdPtr_r <= '0;
            end else begin
                if (pushEn_s) begin
                    fifoMem_r[wrPtr_r] <= InstructionIn;
                    wrPtr_r            <= wrPtr_r + PTR_ONE;
                end
                if (popEn_s) begin
                    rdPtr_r <= rdPtr_r + PTR_ONE;
                end
            end
        end
    end

    // Issue-control FSM: halt and conditional-branch stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
        end else if (FlushIn) begin
            state_r <= (state_r == HALTED) ? HALTED : RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (popEn_s && headHalt_s) begin
                        state_r <= HALTED;
                    end else if (popEn_s && headCondBr_s) begin
                        state_r <= BRANCHWAIT;
                    end else begin
                        state_r <= RUN;
                    end
                end
                BRANCHWAIT: state_r <= BranchResolved ? RUN : BRANCHWAIT;
                HALTED:     state_r <= ResumeIn ? RUN : HALTED;
                default:    state_r <= RUN;
            endcase
        end
    end

    // Output bundle register; a popped halt is consumed without being issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decValid_r <= 1'b0;
            ctrl_r     <= '0;
            fu_r       <= '0;
            imm_r      <= '0;
        end else if (FlushIn) begin
            decValid_r <= 1'b0;
        end else if (popEn_s && !headHalt_s) begin
            decValid_r <= 1'b1;
            ctrl_r     <= headCtrl_s;
            fu_r       <= headFu_s;
            imm_r      <= headImm_s;
        end else if (DecodeReady) begin
            decValid_r <= 1'b0;
        end
    end

    assign InstructionInReady   = inReady_r;
    assign DecodeValid          = decValid_r;
    assign FunctionalUnitEnable = fu_r;
    assign WritebackSource      = ctrl_r.wbSource;
    assign MinorOpcode          = ctrl_r.minorOpcode;
    assign ImmediateEn          = ctrl_r.immediateEn;
    assign ImmediateOut         = imm_r;
    assign RegAAddr             = ctrl_r.regAAddr;
    assign RegBAddr             = ctrl_r.regBAddr;
    assign RegAReadEn           = ctrl_r.regAReadEn;
    assign RegAWriteEn          = ctrl_r.regAWriteEn;
    assign RegBReadEn           = ctrl_r.regBReadEn;
    assign JumpEn               = ctrl_r.jumpEn;
    assign RelativeEn           = ctrl_r.relativeEn;
    assign Halted               = (state_r == HALTED);

endmodule
